piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_serializer.sv | 61 ++++++
 tb/tb_piso_serializer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer:
// FSM state encoding and the shift-direction codes.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load port, pause, and
// back-to-back frames. shift_en qualifies serial_out for a downstream shift register.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             direction,
  input  logic             pause,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic             last;
  logic             accept;

  // Gating shift_en with reset makes an abort take effect in the reset cycle itself.
  assign busy       = (state == SHIFT);
  assign shift_en   = busy & ~pause & ~reset;
  assign last       = shift_en & (cnt == '0);
  assign done       = last;
  assign load_ready = ~busy | last;
  assign accept     = load_valid & load_ready;
  assign serial_out = busy ? ((dir_q == DIR_LSB_FIRST) ? shreg[0] : shreg[WIDTH-1]) : 1'b0;

  // A reload on the last bit takes priority over the shift so frames run gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      dir_q <= DIR_MSB_FIRST;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= load_data;
      dir_q <= direction;
      cnt   <= CW'(WIDTH - 1);
    end else if (shift_en) begin
      shreg <= (dir_q == DIR_LSB_FIRST) ? (shreg >> 1) : (shreg << 1);
      if (last) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: a scoreboard of expected serial bits checked on every
// shift_en cycle, a loopback receiver model, and table-driven plus corner-case frames.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             direction;
  logic             pause;
  logic             serial_out;
  logic             shift_en;
  logic             busy;
  logic             done;

  typedef struct packed {
    logic b;
    logic last;
    logic dir;
  } exp_bit_t;

  typedef struct {
    logic [7:0] data;
    logic       dir;
    logic [7:0] exp_word;
  } vec_t;

  exp_bit_t   sb_q[$];
  int         shift_cyc[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         base_shift;
  int         base_done;
  logic [7:0] rx = '0;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .direction  (direction),
    .pause      (pause),
    .serial_out (serial_out),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Receiver model: pops the expected bit on every shift_en and rebuilds the word.
  always @(negedge clk) begin
    exp_bit_t e;
    cyc++;
    if (reset) begin
      rx = '0;
    end else if (shift_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_shift: got shift_en=1 expected no frame pending");
      end else begin
        e = sb_q.pop_front();
        check_output("serial_bit", serial_out, e.b);
        check_output("done_on_bit", done, e.last);
        rx = e.dir ? {serial_out, rx[7:1]} : {rx[6:0], serial_out};
        shift_cyc.push_back(cyc);
        if (done) done_cnt++;
      end
    end else begin
      check_output("done_idle", done, 1'b0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] data, input logic dir);
    exp_bit_t e;
    for (int i = 0; i < 8; i++) begin
      e.b    = dir ? data[i] : data[7-i];
      e.last = (i == 7);
      e.dir  = dir;
      sb_q.push_back(e);
    end
  endtask

  task automatic mark;
    base_shift = shift_cyc.size();
    base_done  = done_cnt;
  endtask

  task automatic check_frame_stats(input string name, input int exp_shifts, input int exp_dones, input int exp_span);
    int n;
    int span;
    n = shift_cyc.size() - base_shift;
    span = (n > 0) ? (shift_cyc[shift_cyc.size()-1] - shift_cyc[base_shift] + 1) : 0;
    check_output({name, "_shifts"}, n, exp_shifts);
    check_output({name, "_dones"}, done_cnt - base_done, exp_dones);
    check_output({name, "_span"}, span, exp_span);
  endtask

  // Offers one word while the block is idle; the accept happens on the next edge.
  task automatic apply_stimulus(input logic [7:0] data, input logic dir);
    load_valid = 1'b1;
    load_data  = data;
    direction  = dir;
    tick();
    load_valid = 1'b0;
    push_frame(data, dir);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'hAA, dir: DIR_MSB_FIRST, exp_word: 8'hAA};
    vecs[1] = '{data: 8'hAA, dir: DIR_LSB_FIRST, exp_word: 8'hAA};
    vecs[2] = '{data: 8'h3C, dir: DIR_MSB_FIRST, exp_word: 8'h3C};
    vecs[3] = '{data: 8'h81, dir: DIR_LSB_FIRST, exp_word: 8'h81};
    vecs[4] = '{data: 8'h00, dir: DIR_MSB_FIRST, exp_word: 8'h00};
    vecs[5] = '{data: 8'hFF, dir: DIR_LSB_FIRST, exp_word: 8'hFF};

    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    direction  = 1'b0;
    pause      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_shift_en", shift_en, 1'b0);
    check_output("rst_load_ready", load_ready, 1'b1);
    check_output("rst_done", done, 1'b0);
    check_output("rst_serial_out", serial_out, 1'b0);

    // Single frames in both directions, rebuilt by the loopback receiver.
    for (int v = 0; v < 6; v++) begin
      mark();
      apply_stimulus(vecs[v].data, vecs[v].dir);
      @(negedge clk);
      check_output("first_bit_busy", busy, 1'b1);
      check_output("first_bit_ready", load_ready, 1'b0);
      wait_idle("vec");
      check_output("vec_loopback", rx, vecs[v].exp_word);
      check_output("vec_ready_after", load_ready, 1'b1);
      check_frame_stats("vec", 8, 1, 8);
    end

    // Back-to-back frames with load_valid held high.
    mark();
    load_valid = 1'b1;
    load_data  = 8'hF0;
    direction  = DIR_MSB_FIRST;
    tick();
    push_frame(8'hF0, DIR_MSB_FIRST);
    load_data = 8'h0F;
    @(negedge clk);
    check_output("b2b_ready_mid", load_ready, 1'b0);
    repeat (7) tick();
    @(negedge clk);
    check_output("b2b_ready_last", load_ready, 1'b1);
    push_frame(8'h0F, DIR_MSB_FIRST);
    tick();
    load_valid = 1'b0;
    wait_idle("b2b");
    check_output("b2b_loopback", rx, 8'h0F);
    check_frame_stats("b2b", 16, 2, 16);

    // Pause for three cycles after the second bit.
    mark();
    apply_stimulus(8'hC3, DIR_MSB_FIRST);
    tick();
    tick();
    pause = 1'b1;
    @(negedge clk);
    check_output("pause_shift_en", shift_en, 1'b0);
    check_output("pause_serial", serial_out, 1'b0);
    check_output("pause_ready", load_ready, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check_output("pause_hold_shift_en", shift_en, 1'b0);
    check_output("pause_hold_serial", serial_out, 1'b0);
    tick();
    pause = 1'b0;
    wait_idle("pause");
    check_output("pause_loopback", rx, 8'hC3);
    check_frame_stats("pause", 8, 1, 11);

    // Reset after three bits, with a competing load offered during reset.
    mark();
    apply_stimulus(8'hFF, DIR_MSB_FIRST);
    tick();
    tick();
    tick();
    check_output("abort_bits_sent", shift_cyc.size() - base_shift, 3);
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    sb_q.delete();
    @(negedge clk);
    check_output("abort_shift_en_in_reset", shift_en, 1'b0);
    tick();
    reset      = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_shift_en", shift_en, 1'b0);
    check_output("abort_ready", load_ready, 1'b1);
    mark();
    apply_stimulus(8'h01, DIR_LSB_FIRST);
    wait_idle("after_abort");
    check_output("after_abort_loopback", rx, 8'h01);
    check_frame_stats("after_abort", 8, 1, 8);

    // A load offered mid-frame (with a new direction) must be ignored.
    mark();
    apply_stimulus(8'h0F, DIR_MSB_FIRST);
    tick();
    tick();
    load_valid = 1'b1;
    load_data  = 8'h55;
    direction  = DIR_LSB_FIRST;
    @(negedge clk);
    check_output("ignored_ready", load_ready, 1'b0);
    tick();
    load_valid = 1'b0;
    direction  = DIR_MSB_FIRST;
    wait_idle("ignored");
    repeat (4) @(negedge clk);
    check_output("ignored_loopback", rx, 8'h0F);
    check_output("ignored_busy", busy, 1'b0);
    check_frame_stats("ignored", 8, 1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
